// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier doing one shift-add per clock through an external ALU.
module shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [5:0]         alu_signal,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               hi_nonzero
);
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, calc_prod;
    logic [5:0]         cnt;
    logic               last;

    assign last    = cnt == 6'(ITER - 1);
    assign busy    = state == CALC;
    assign done    = state == DONE;
    assign product = prod;

    // The ALU carry becomes the new top bit, so no product bit is ever dropped.
    always_comb begin
        next_state = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_signal = FN_AND;
        calc_prod  = prod[0] ? {alu_cout, alu_result, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
        case (state)
            IDLE: next_state = start ? CALC : IDLE;
            CALC: begin
                alu_a      = prod[2*WIDTH-1:WIDTH];
                alu_b      = mcand;
                alu_signal = FN_ADD;
                next_state = last ? DONE : CALC;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mcand      <= '0;
            prod       <= '0;
            cnt        <= '0;
            hi_nonzero <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                mcand <= multiplicand;
                prod  <= {{WIDTH{1'b0}}, multiplier};
                cnt   <= '0;
            end else if (state == CALC) begin
                prod <= calc_prod;
                cnt  <= cnt + 6'd1;
                if (last)
                    hi_nonzero <= |calc_prod[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_shift_add_multiplier;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0, multiplier = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_signal;
    logic        alu_cout, busy, done, hi_nonzero;
    logic [63:0] product;
    logic [32:0] sum;

    typedef struct {
        logic [63:0] p;
        logic        h;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0, busy_run = 0;

    shift_add_multiplier dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .busy(busy), .done(done), .product(product), .hi_nonzero(hi_nonzero)
    );

    // Behavioural ALU: ADD with carry-out, otherwise AND.
    assign sum        = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = (alu_signal == FN_ADD) ? sum[31:0] : (alu_a & alu_b);
    assign alu_cout   = (alu_signal == FN_ADD) ? sum[32] : 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("alu_signal", 64'(alu_signal), 64'(busy ? FN_ADD : FN_AND));
            if (busy)
                busy_run++;
            else begin
                if (done) check("busy_len", 64'(busy_run), 64'd32);
                busy_run = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", product, e.p);
                    check("hi_nonzero", 64'(hi_nonzero), 64'(e.h));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p, input bit push);
        @(negedge clk);
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        if (push) exp_q.push_back('{p, |p[63:32], cyc + 32});
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_hi", 64'(hi_nonzero), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_signal", 64'(alu_signal), 64'(FN_AND));
        reset = 1'b0;

        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        drain();
        issue(32'd0, 32'h1234_5678, 64'd0, 1'b1);
        drain();

        issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        multiplicand = 32'hDEAD_BEEF;
        multiplier = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b0;
        multiplicand = 32'h0;
        drain();

        issue(32'd7, 32'd9, 64'd63, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_product", product, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        issue(32'd7, 32'd9, 64'd63, 1'b1);
        drain();

        @(negedge clk);
        start = 1'b1;
        multiplicand = 32'h0001_0001;
        multiplier = 32'h0001_0001;
        @(negedge clk);
        c0 = cyc;
        check("b2b_busy0", 64'(busy), 64'd1);
        exp_q.push_back('{64'h0000_0001_0002_0001, 1'b1, c0 + 32});
        exp_q.push_back('{64'h0000_0001_FFFF_FFFE, 1'b1, c0 + 66});
        exp_q.push_back('{64'd42, 1'b0, c0 + 100});
        for (int i = 0; i < 80 && cyc < c0 + 33; i++) @(negedge clk);
        multiplicand = 32'hFFFF_FFFF;
        multiplier = 32'd2;
        for (int i = 0; i < 80 && cyc < c0 + 67; i++) @(negedge clk);
        multiplicand = 32'd6;
        multiplier = 32'd7;
        for (int i = 0; i < 80 && cyc < c0 + 68; i++) @(negedge clk);
        check("b2b_busy2", 64'(busy), 64'd1);
        start = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
